// File: rtl/uart_pkg.sv
// Shared UART definitions used by the TX scheduler and the baud-tick divider.
// Contents:
//   state_t   - frame sequencer states (IDLE, START, DATA, PARITY, STOP)
//   CLK_HZ    - system clock frequency
//   BAUD_9600 - default line rate
//   UART_BITS - data bits per frame
//   baud_div  - clk_in cycles per bit for a given clock and baud rate
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int CLK_HZ    = 50_000_000;
  localparam int BAUD_9600 = 9600;
  localparam int UART_BITS = 8;

  function automatic int baud_div(input int clk, input int baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider. The counter runs 0..DIV-1, and tick is high for the one
// cycle the counter sits at DIV-1. Holding clr parks the counter at 0, so the
// first tick after clr drops arrives exactly DIV cycles later.
// Ports:
//   clk_in - system clock
//   rst_n  - synchronous active-low reset
//   clr    - synchronous clear, holds the counter at 0
//   tick   - one-cycle pulse marking the end of a bit period
module uart_baud_tick #(
  parameter int DIV = 5208
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART TX line between N_REQ byte
// requesters and serialises each granted byte as start + 8 data (LSB first)
// + optional even parity + STOP_BITS stop bits. All bit timing comes from a
// baud divider that is held cleared while idle, so every frame starts with
// a full-length start bit.
// Optional build macro: UART_TX_SCHED_PARITY_EN adds an even-parity bit
// between data bit 7 and the stop bit(s).
// Ports:
//   clk_in - system clock
//   rst_n  - synchronous active-low reset (aborts any frame in progress)
//   req    - per-requester byte-ready levels
//   data   - requester i's byte in data[8i+7:8i]
//   gnt    - one-hot, one-cycle pulse when a byte is captured
//   tx     - serial line, idle high
//   busy   - high while a frame is in progress
//   cur_id - requester being (or last) transmitted
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int BAUD_DIV  = baud_div(CLK_HZ, BAUD_9600),
  parameter int STOP_BITS = 1
) (
  input  logic                       clk_in,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [8*N_REQ-1:0]         data,
  output logic [N_REQ-1:0]           gnt,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   cur_id
);

  localparam int ID_W = $clog2(N_REQ);

  state_t              state;
  logic [ID_W-1:0]     last;
  logic [ID_W-1:0]     sel;
  logic [ID_W-1:0]     cand;
  logic                found;
  logic [7:0]          sel_byte;
  logic [7:0]          shift;
  logic [2:0]          bit_idx;
  logic                stop_cnt;
  logic                tick;
`ifdef UART_TX_SCHED_PARITY_EN
  logic                par_bit;
`endif

  // Divider only runs while a frame is being sent.
  uart_baud_tick #(.DIV(BAUD_DIV)) u_tick (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .clr    (state == IDLE),
    .tick   (tick)
  );

  // Round-robin pick: first set req bit searching upward from last+1.
  // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
  always_comb begin
    sel   = last;
    cand  = last;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(last) + k) % N_REQ);
      if (!found && req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_byte = data[7:0];
    for (int i = 0; i < N_REQ; i++) begin
      if (sel == ID_W'(i)) sel_byte = data[i*8 +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state    <= IDLE;
      last     <= ID_W'(N_REQ - 1);
      gnt      <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      cur_id   <= '0;
      shift    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
`ifdef UART_TX_SCHED_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt     <= N_REQ'(1) << sel;
            shift   <= sel_byte;
            cur_id  <= sel;
            last    <= sel;
            busy    <= 1'b1;
            tx      <= 1'b0;
            state   <= START;
`ifdef UART_TX_SCHED_PARITY_EN
            par_bit <= ^sel_byte;
`endif
          end
        end
        START: begin
          if (tick) begin
            tx      <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx != 3'(UART_BITS - 1)) begin
              // shift[1] is the bit that lands in shift[0] after this shift.
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end else begin
`ifdef UART_TX_SCHED_PARITY_EN
              tx       <= par_bit;
              state    <= PARITY;
`else
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
`endif
            end
          end
        end
`ifdef UART_TX_SCHED_PARITY_EN
        PARITY: begin
          if (tick) begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with N_REQ=3, BAUD_DIV=4, STOP_BITS=1.
// Frames are checked bit by bit at mid-bit sample points, for length (busy
// cycles), tx stability inside each bit, grant latency, grant identity and
// round-robin order. Parity expectations follow UART_TX_SCHED_PARITY_EN.
module tb_uart_tx_sched;

  localparam int N    = 3;
  localparam int DIV  = 4;
  localparam int SB   = 1;
`ifdef UART_TX_SCHED_PARITY_EN
  localparam int PAR  = 1;
`else
  localparam int PAR  = 0;
`endif
  localparam int FRAME_BITS = 10 + SB - 1 + PAR;
  localparam int FRAME_CYC  = FRAME_BITS * DIV;

  logic           clk_in;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] data;
  logic [N-1:0]   gnt;
  logic           tx;
  logic           busy;
  logic [1:0]     cur_id;

  int checks   = 0;
  int failures = 0;

  uart_tx_sched #(.N_REQ(N), .BAUD_DIV(DIV), .STOP_BITS(SB)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .req    (req),
    .data   (data),
    .gnt    (gnt),
    .tx     (tx),
    .busy   (busy),
    .cur_id (cur_id)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  // Expected line levels, index = bit position in time order.
  function automatic logic [11:0] frame_bits(input logic [7:0] b);
    logic [11:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[i];
    if (PAR == 1) f[9] = ^b;
    for (int k = FRAME_BITS; k < 12; k++) f[k] = 1'b0;
    return f;
  endfunction

  task automatic wait_gnt(output int waits);
    waits = 0;
    do begin
      step();
      waits++;
    end while (gnt == '0 && waits < 50);
  endtask

  // Waits for the next grant, then follows the whole frame. drop is cleared
  // from req right after the grant; pulse is raised on cycles 8..9 of the frame.
  task automatic run_frame(input int exp_id, input logic [7:0] b, input logic [N-1:0] drop,
                           input logic [N-1:0] pulse, input int exp_wait, input string tag);
    int          waits;
    int          busy_n;
    int          glitches;
    int          extra;
    logic [11:0] bits;
    logic        prev;
    wait_gnt(waits);
    check({tag, "_lat"}, waits, exp_wait);
    check({tag, "_gnt"}, gnt, 32'(1) << exp_id);
    check({tag, "_id"}, cur_id, exp_id);
    req      = req & ~drop;
    bits     = '0;
    busy_n   = 0;
    glitches = 0;
    extra    = 0;
    prev     = tx;
    for (int c = 0; c < FRAME_CYC + 4; c++) begin
      if (c > 0) step();
      if (c > 0 && gnt != '0) extra++;
      if (c % DIV != 0 && tx !== prev) glitches++;
      prev = tx;
      if (c % DIV == DIV / 2 && c / DIV < FRAME_BITS) bits[c / DIV] = tx;
      if (busy) busy_n++;
      if (c == 8) req = req | pulse;
      if (c == 10) req = req & ~pulse;
      if (!busy) break;
    end
    check({tag, "_bits"}, bits, frame_bits(b));
    check({tag, "_len"}, busy_n, FRAME_CYC);
    check({tag, "_glitch"}, glitches, 0);
    check({tag, "_xgnt"}, extra, 0);
    check({tag, "_txidle"}, tx, 1);
  endtask

  initial begin
    int bad;
    int waits;
    rst_n = 1'b0;
    req   = '0;
    data  = '0;

    // 1: reset state, then 100 idle cycles with no requests.
    do_reset();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_gnt", gnt, 0);
    check("rst_id", cur_id, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0 || gnt !== '0) bad++;
    end
    check("idle100", bad, 0);

    // 2: single byte 0xA5 from requester 0.
    data[7:0] = 8'hA5;
    req       = 3'b001;
    run_frame(0, 8'hA5, 3'b001, 3'b000, 1, "t2");

    // 4: req[1] pulsed for two cycles mid-frame must never be granted.
    data[7:0] = 8'h3C;
    req       = 3'b001;
    run_frame(0, 8'h3C, 3'b001, 3'b010, 1, "t4");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (gnt !== '0 || busy !== 1'b0) bad++;
    end
    check("t4_nostale", bad, 0);

    // 3: all requesters held high -> order 0,1,2,0 with one idle cycle between.
    do_reset();
    data = {8'h33, 8'h22, 8'h11};
    req  = 3'b111;
    run_frame(0, 8'h11, 3'b000, 3'b000, 1, "t3a");
    run_frame(1, 8'h22, 3'b000, 3'b000, 1, "t3b");
    run_frame(2, 8'h33, 3'b000, 3'b000, 1, "t3c");
    run_frame(0, 8'h11, 3'b111, 3'b000, 1, "t3d");

    // 5: reset during data bit 3 aborts the frame and restores the pointer.
    data[7:0] = 8'hC3;
    req       = 3'b001;
    wait_gnt(waits);
    check("t5_gnt", gnt, 3'b001);
    req = '0;
    repeat (17) step();
    rst_n = 1'b0;
    step();
    check("t5_tx", tx, 1);
    check("t5_busy", busy, 0);
    check("t5_gnt0", gnt, 0);
    check("t5_id", cur_id, 0);
    rst_n = 1'b1;

    // 6: after reset requester 0 wins over 1; 0x07 has odd weight (parity 1).
    data[7:0]  = 8'h07;
    data[15:8] = 8'h5A;
    req        = 3'b011;
    run_frame(0, 8'h07, 3'b001, 3'b000, 1, "t6a");
    run_frame(1, 8'h5A, 3'b010, 3'b000, 1, "t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
